// File: rtl/init_done_reset_seq.sv
//------------------------------------------------------------------------------
// init_done_reset_seq
//
// Power-up reset sequencer for the fabric. It holds the fabric in reset until
// the device has finished power-on reset, device initialisation, both I/O bank
// calibrations and the clock-conditioning lock. It then waits a fixed settling
// delay and releases FABRIC_RESET_N. Loss of POR, calibration or lock drops
// the sequencer back to the matching wait state.
//
// Parameters
//   DELAY_CYCLES   : post-lock release delay in CLK cycles (1..255)
//   TIMEOUT_CYCLES : calibration/lock watchdog limit in CLK cycles (2..65535)
//
// Ports
//   CLK                 in   fabric clock, all logic on the rising edge
//   RESET               in   synchronous active-high reset
//   FABRIC_POR_N        in   async power-on-reset done
//   DEVICE_INIT_DONE    in   async device init complete
//   BANK_0_CALIB_STATUS in   async HSIO bank 0 calibration done
//   BANK_1_CALIB_STATUS in   async GPIO bank 1 calibration done
//   PLL_LOCK            in   async clock-conditioning lock
//   FABRIC_RESET_N      out  registered active-low fabric reset
//   READY               out  registered, high only while in RUN
//   STATE               out  current state encoding
//   TIMEOUT             out  sticky watchdog flag
//
// Build option
//   INIT_DONE_RESET_SEQ_TIMEOUT_EN : when defined, a 16-bit watchdog counts
//   cycles spent continuously in WAIT_CALIB/WAIT_LOCK and sets TIMEOUT once it
//   reaches TIMEOUT_CYCLES. When undefined, TIMEOUT is tied to 0.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module init_done_reset_seq #(
    parameter int unsigned DELAY_CYCLES   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       FABRIC_POR_N,
    input  logic       DEVICE_INIT_DONE,
    input  logic       BANK_0_CALIB_STATUS,
    input  logic       BANK_1_CALIB_STATUS,
    input  logic       PLL_LOCK,
    output logic       FABRIC_RESET_N,
    output logic       READY,
    output logic [2:0] STATE,
    output logic       TIMEOUT
);

    // Out-of-range parameters are rejected at elaboration.
    if (DELAY_CYCLES < 1 || DELAY_CYCLES > 255 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("init_done_reset_seq: DELAY_CYCLES or TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [2:0] {
        ST_WAIT_POR   = 3'd0,
        ST_WAIT_INIT  = 3'd1,
        ST_WAIT_CALIB = 3'd2,
        ST_WAIT_LOCK  = 3'd3,
        ST_DELAY      = 3'd4,
        ST_RUN        = 3'd5
    } state_e;

    localparam logic [7:0] DLY_LOAD = 8'(DELAY_CYCLES - 1);

    //--------------------------------------------------------------------------
    // Two-flop synchronizers, one per asynchronous input.
    // Bit order: {lock, calib1, calib0, init, por_n}
    //--------------------------------------------------------------------------
    logic [4:0] async_in;
    logic [4:0] meta_q;
    logic [4:0] sync_q;

    assign async_in = {PLL_LOCK, BANK_1_CALIB_STATUS, BANK_0_CALIB_STATUS,
                       DEVICE_INIT_DONE, FABRIC_POR_N};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    logic por_s;
    logic init_s;
    logic calib_s;
    logic lock_s;

    assign por_s   = sync_q[0];
    assign init_s  = sync_q[1];
    assign calib_s = sync_q[2] & sync_q[3];
    assign lock_s  = sync_q[4];

    //--------------------------------------------------------------------------
    // Sequencer FSM
    //--------------------------------------------------------------------------
    state_e     state_q;
    state_e     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_WAIT_POR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Loss events are checked in priority order POR > calib > lock ahead of
    // any forward step. The delay counter is only meaningful in DELAY; it is
    // loaded on the transition into DELAY so a re-entry always restarts the
    // full settling period.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_WAIT_POR: begin
                if (por_s) state_d = ST_WAIT_INIT;
            end
            ST_WAIT_INIT: begin
                if (!por_s)      state_d = ST_WAIT_POR;
                else if (init_s) state_d = ST_WAIT_CALIB;
            end
            ST_WAIT_CALIB: begin
                if (!por_s)       state_d = ST_WAIT_POR;
                else if (calib_s) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (!por_s) begin
                    state_d = ST_WAIT_POR;
                end else if (lock_s) begin
                    state_d = ST_DELAY;
                    cnt_d   = DLY_LOAD;
                end
            end
            ST_DELAY: begin
                if (!por_s)             state_d = ST_WAIT_POR;
                else if (!calib_s)      state_d = ST_WAIT_CALIB;
                else if (!lock_s)       state_d = ST_WAIT_LOCK;
                else if (cnt_q == 8'd0) state_d = ST_RUN;
                else                    cnt_d   = cnt_q - 8'd1;
            end
            ST_RUN: begin
                if (!por_s)        state_d = ST_WAIT_POR;
                else if (!calib_s) state_d = ST_WAIT_CALIB;
                else if (!lock_s)  state_d = ST_WAIT_LOCK;
            end
            default: state_d = ST_WAIT_POR;
        endcase
    end

    //--------------------------------------------------------------------------
    // Output register: follows STATE==RUN one cycle later.
    //--------------------------------------------------------------------------
    logic run_q;
    logic run_d;

    assign run_d = (state_q == ST_RUN);

    always_ff @(posedge CLK) begin
        if (RESET) run_q <= 1'b0;
        else       run_q <= run_d;
    end

    assign FABRIC_RESET_N = run_q;
    assign READY          = run_q;
    assign STATE          = state_q;

`ifdef INIT_DONE_RESET_SEQ_TIMEOUT_EN
    //--------------------------------------------------------------------------
    // Watchdog: counts consecutive cycles in WAIT_CALIB/WAIT_LOCK (treated as
    // one window) and latches TIMEOUT once the limit is reached. It only
    // observes the FSM; it never influences a transition.
    //--------------------------------------------------------------------------
    logic [15:0] wd_q;
    logic [15:0] wd_d;
    logic        to_q;
    logic        to_d;
    logic        in_window;

    assign in_window = (state_q == ST_WAIT_CALIB) || (state_q == ST_WAIT_LOCK);

    always_comb begin
        wd_d = '0;
        to_d = to_q;
        if (in_window) begin
            wd_d = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
            if ((17'(wd_q) + 17'd1) >= 17'(TIMEOUT_CYCLES)) to_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign TIMEOUT = to_q;
`else
    assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_init_done_reset_seq.sv
`timescale 1ns/1ps

module tb_init_done_reset_seq;

    logic       CLK;
    logic       RESET;
    logic       FABRIC_POR_N;
    logic       DEVICE_INIT_DONE;
    logic       BANK_0_CALIB_STATUS;
    logic       BANK_1_CALIB_STATUS;
    logic       PLL_LOCK;
    logic       FABRIC_RESET_N;
    logic       READY;
    logic [2:0] STATE;
    logic       TIMEOUT;

    int vectors;
    int miscompares;

    init_done_reset_seq #(
        .DELAY_CYCLES   (16),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .FABRIC_POR_N        (FABRIC_POR_N),
        .DEVICE_INIT_DONE    (DEVICE_INIT_DONE),
        .BANK_0_CALIB_STATUS (BANK_0_CALIB_STATUS),
        .BANK_1_CALIB_STATUS (BANK_1_CALIB_STATUS),
        .PLL_LOCK            (PLL_LOCK),
        .FABRIC_RESET_N      (FABRIC_RESET_N),
        .READY               (READY),
        .STATE               (STATE),
        .TIMEOUT             (TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish, got running want finished");
        $fatal(1);
    end

    // Advance one rising edge and settle; inputs driven after this are
    // sampled on the following edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_all(input logic v);
        FABRIC_POR_N        = v;
        DEVICE_INIT_DONE    = v;
        BANK_0_CALIB_STATUS = v;
        BANK_1_CALIB_STATUS = v;
        PLL_LOCK            = v;
    endtask

    task automatic hard_reset();
        RESET = 1'b1;
        set_all(1'b0);
        step();
        step();
        RESET = 1'b0;
    endtask

    // Bring-up from WAIT_POR with all inputs rising together, k edges later:
    // edges 1-2 synchronizer, 3/4/5 WAIT_INIT/WAIT_CALIB/WAIT_LOCK,
    // 6..21 DELAY (16 cycles), 22 RUN, 23 output register high.
    function automatic logic [2:0] bringup_state(input int k);
        if (k <= 2)  return 3'd0;
        if (k <= 5)  return 3'(k - 2);
        if (k <= 21) return 3'd4;
        return 3'd5;
    endfunction

    task automatic go_run();
        hard_reset();
        set_all(1'b1);
        repeat (23) step();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        set_all(1'b1);
        repeat (3) step();
        vectors++;
        if (STATE !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_state got %0d want 0", STATE);
        end
        vectors++;
        if (FABRIC_RESET_N !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_frn got %b want 0", FABRIC_RESET_N);
        end
        vectors++;
        if (READY !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready got %b want 0", READY);
        end
        vectors++;
        if (TIMEOUT !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_timeout got %b want 0", TIMEOUT);
        end
        set_all(1'b0);
        RESET = 1'b0;
        repeat (5) step();
        vectors++;
        if (STATE !== 3'd0) begin
            miscompares++;
            $display("FAIL idle_wait_por got %0d want 0", STATE);
        end
    endtask

    task automatic test_bringup();
        hard_reset();
        set_all(1'b1);
        for (int k = 1; k <= 24; k++) begin
            step();
            vectors++;
            if (STATE !== bringup_state(k)) begin
                miscompares++;
                $display("FAIL bringup_state k=%0d got %0d want %0d", k, STATE, bringup_state(k));
            end
            vectors++;
            if (FABRIC_RESET_N !== (k >= 23)) begin
                miscompares++;
                $display("FAIL bringup_frn k=%0d got %b want %b", k, FABRIC_RESET_N, (k >= 23));
            end
            vectors++;
            if (READY !== (k >= 23)) begin
                miscompares++;
                $display("FAIL bringup_ready k=%0d got %b want %b", k, READY, (k >= 23));
            end
        end
    endtask

    // Lock low for 5 cycles: WAIT_LOCK at edge 3, reset asserted at edge 4;
    // relock seen at edge 7, DELAY 8..23, RUN 24, release 25.
    task automatic test_lock_loss();
        logic [2:0] exp_st;
        logic       exp_frn;
        go_run();
        PLL_LOCK = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            step();
            if (k == 5) PLL_LOCK = 1'b1;
            if (k < 3)       exp_st = 3'd5;
            else if (k < 8)  exp_st = 3'd3;
            else if (k < 24) exp_st = 3'd4;
            else             exp_st = 3'd5;
            exp_frn = (k < 4) || (k >= 25);
            vectors++;
            if (STATE !== exp_st) begin
                miscompares++;
                $display("FAIL lockloss_state k=%0d got %0d want %0d", k, STATE, exp_st);
            end
            vectors++;
            if (FABRIC_RESET_N !== exp_frn) begin
                miscompares++;
                $display("FAIL lockloss_frn k=%0d got %b want %b", k, FABRIC_RESET_N, exp_frn);
            end
        end
    endtask

    task automatic test_por_lock_same_cycle();
        logic [2:0] exp_st;
        hard_reset();
        set_all(1'b1);
        repeat (6) step();
        vectors++;
        if (STATE !== 3'd4) begin
            miscompares++;
            $display("FAIL porlock_in_delay got %0d want 4", STATE);
        end
        FABRIC_POR_N = 1'b0;
        PLL_LOCK     = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_st = (k < 3) ? 3'd4 : 3'd0;
            vectors++;
            if (STATE !== exp_st) begin
                miscompares++;
                $display("FAIL porlock_state k=%0d got %0d want %0d", k, STATE, exp_st);
            end
        end
    endtask

    task automatic test_calib_loss();
        logic [2:0] exp_st;
        go_run();
        BANK_1_CALIB_STATUS = 1'b0;
        PLL_LOCK            = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_st = (k < 3) ? 3'd5 : 3'd2;
            vectors++;
            if (STATE !== exp_st) begin
                miscompares++;
                $display("FAIL calibloss_state k=%0d got %0d want %0d", k, STATE, exp_st);
            end
            vectors++;
            if (FABRIC_RESET_N !== (k < 4)) begin
                miscompares++;
                $display("FAIL calibloss_frn k=%0d got %b want %b", k, FABRIC_RESET_N, (k < 4));
            end
        end
        BANK_1_CALIB_STATUS = 1'b1;
        PLL_LOCK            = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k < 3)       exp_st = 3'd2;
            else if (k == 3) exp_st = 3'd3;
            else             exp_st = 3'd4;
            vectors++;
            if (STATE !== exp_st) begin
                miscompares++;
                $display("FAIL recalib_state k=%0d got %0d want %0d", k, STATE, exp_st);
            end
        end
    endtask

    task automatic test_reset_in_run();
        go_run();
        RESET = 1'b1;
        step();
        vectors++;
        if (STATE !== 3'd0) begin
            miscompares++;
            $display("FAIL runreset_state got %0d want 0", STATE);
        end
        vectors++;
        if (READY !== 1'b0) begin
            miscompares++;
            $display("FAIL runreset_ready got %b want 0", READY);
        end
        vectors++;
        if (FABRIC_RESET_N !== 1'b0) begin
            miscompares++;
            $display("FAIL runreset_frn got %b want 0", FABRIC_RESET_N);
        end
        RESET = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            step();
            vectors++;
            if (STATE !== bringup_state(k)) begin
                miscompares++;
                $display("FAIL restart_state k=%0d got %0d want %0d", k, STATE, bringup_state(k));
            end
        end
        vectors++;
        if (FABRIC_RESET_N !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_frn got %b want 1", FABRIC_RESET_N);
        end
    endtask

    // WAIT_CALIB is entered on edge 4, so 100 cycles there ends on edge 104.
    task automatic test_timeout();
        logic exp_to;
        hard_reset();
        set_all(1'b1);
        BANK_1_CALIB_STATUS = 1'b0;
        for (int k = 1; k <= 110; k++) begin
            step();
`ifdef INIT_DONE_RESET_SEQ_TIMEOUT_EN
            exp_to = (k >= 104);
`else
            exp_to = 1'b0;
`endif
            vectors++;
            if (TIMEOUT !== exp_to) begin
                miscompares++;
                $display("FAIL timeout_rise k=%0d got %b want %b", k, TIMEOUT, exp_to);
            end
        end
        vectors++;
        if (STATE !== 3'd2) begin
            miscompares++;
            $display("FAIL timeout_stuck_state got %0d want 2", STATE);
        end
        BANK_1_CALIB_STATUS = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
`ifdef INIT_DONE_RESET_SEQ_TIMEOUT_EN
            exp_to = 1'b1;
`else
            exp_to = 1'b0;
`endif
            vectors++;
            if (TIMEOUT !== exp_to) begin
                miscompares++;
                $display("FAIL timeout_sticky k=%0d got %b want %b", k, TIMEOUT, exp_to);
            end
        end
        vectors++;
        if (STATE !== 3'd5) begin
            miscompares++;
            $display("FAIL timeout_run_state got %0d want 5", STATE);
        end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        vectors++;
        if (TIMEOUT !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear got %b want 0", TIMEOUT);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RESET       = 1'b1;
        set_all(1'b0);
        test_reset();
        test_bringup();
        test_lock_loss();
        test_por_lock_same_cycle();
        test_calib_loss();
        test_reset_in_run();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
